alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Registered, parametrised ALU with valid/ready handshake; successor to the 32-bit combinational ALU.
//  Adds carry-chained ADC/SBB, multi-cycle shift-by-count and iterative multiply, full flag set.
//  Sits between the register file read stage and writeback; one operation in flight at a time.
// PARAMETERS
//  WIDTH  32  operand/result width (>=4)
//  CNT_W  $clog2(WIDTH)  shift-count width taken from in_B[CNT_W-1:0]
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  reset      in   1      synchronous, active-high
//  enable     in   1      active low; when high, no new operation is accepted
//  in_valid   in   1      operation request
//  in_ready   out  1      block can accept; transfer when in_valid & in_ready & !enable
//  mode       in   4      operation select (encodings below)
//  in_A       in   WIDTH  operand A
//  in_B       in   WIDTH  operand B / shift count
//  carry_in   in   1      carry/borrow in
//  out_valid  out  1      result registered and valid
//  out_ready  in   1      consumer accepts result
//  out        out  WIDTH  result
//  carry_out  out  1      carry flag
//  zero_flag  out  1      out == 0
//  neg_flag   out  1      out[WIDTH-1]
//  ovf_flag   out  1      signed overflow (ADD/SUB/ADC/SBB only, else 0)
//  illegal    out  1      mode 14/15 requested
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, out=0, all flags 0, FSM=IDLE. Reset mid-operation aborts it; no result emitted.
//  Accept: operands, mode, carry_in latched on transfer cycle N; inputs may change afterwards.
//  FSM: IDLE -(accept, 1-cycle op)-> DONE; IDLE -(accept, iterative op)-> BUSY; BUSY -(counter==0)-> DONE;
//   DONE -(out_ready)-> IDLE. in_ready=1 only in IDLE; combinational in_ready from out_ready not allowed.
//  DONE holds out/flags stable until out_ready; out_valid=1 exactly in DONE.
//  Modes: 0 AND,1 OR,2 XOR,5 NOT(A): carry_out=carry_in.
//   3 SHCL: out={A[W-2:0],cin}, cout=A[W-1]. 4 SHCR: out={cin,A[W-1:1]}, cout=A[0].
//   7 ADD: {cout,out}=A+B. 6 SUB: {cout,out}=A+~B+1 (cout=1 means no borrow).
//   8 ADC: A+B+cin. 9 SBB: A+~B+cin. All sums computed WIDTH+1 wide.
//   10 SHL, 11 SHR (logical), 12 SAR: by n=in_B[CNT_W-1:0], one bit per cycle; cout=last bit shifted out, cin if n=0.
//   13 MUL: unsigned shift-add, low WIDTH bits in out; cout=1 iff high WIDTH bits nonzero.
//   14,15: out=0, cout=0, illegal=1 (illegal=0 for all other modes), 1-cycle.
//  Latency (accept cycle N -> out_valid): 1-cycle ops N+1; shifts N+1+n; MUL N+1+WIDTH.
//  ovf = (A_msb==B'_msb)&&(out_msb!=A_msb), B' = B or ~B as used in the adder.
//  zero_flag/neg_flag always derived from final out, registered with it.
//  in_valid while BUSY/DONE ignored (no transfer). enable toggling while BUSY does not affect the op in flight.
// STRUCTURE
//  Shared include alu_defs.vh: mode localparams (MODE_AND..MODE_MUL), FSM state encodings.
//  Sub-module alu_seq_iter: iterative shifter/multiplier (start, op, A, B, n -> done, result, cout);
//   top holds handshake FSM, single-cycle datapath, flag logic, output registers.
// TESTING (WIDTH=32)
//  ADD A=FFFFFFFF B=1 -> at N+1 out=0, cout=1, zero=1, ovf=0.
//  SUB A=5 B=7 -> out=FFFFFFFE, cout=0, neg=1; ADD 7FFFFFFF+1 -> out=80000000, ovf=1.
//  SHL A=1 n=31 -> out_valid at N+32, out=80000000, cout=0; in_ready low N+1..N+32, extra in_valid ignored.
//  MUL 00010000*00010000 -> N+33: out=0, cout=1, zero=1; MUL 3*5 -> out=F, cout=0.
//  out_ready low 3 cycles in DONE -> out/flags stable, in_ready=0; next accept only after handshake.
//  reset during MUL at N+10 -> next cycle out_valid=0, in_ready=1; mode 14 -> out=0, illegal=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared mode encodings, FSM states and flag bundle for the sequential ALU.
// Pure definitions: no latency, no backpressure.
// Imported by alu_seq and alu_seq_iter.
package alu_seq_pkg;

    localparam logic [3:0] MODE_AND  = 4'd0;
    localparam logic [3:0] MODE_OR   = 4'd1;
    localparam logic [3:0] MODE_XOR  = 4'd2;
    localparam logic [3:0] MODE_SHCL = 4'd3;
    localparam logic [3:0] MODE_SHCR = 4'd4;
    localparam logic [3:0] MODE_NOT  = 4'd5;
    localparam logic [3:0] MODE_SUB  = 4'd6;
    localparam logic [3:0] MODE_ADD  = 4'd7;
    localparam logic [3:0] MODE_ADC  = 4'd8;
    localparam logic [3:0] MODE_SBB  = 4'd9;
    localparam logic [3:0] MODE_SHL  = 4'd10;
    localparam logic [3:0] MODE_SHR  = 4'd11;
    localparam logic [3:0] MODE_SAR  = 4'd12;
    localparam logic [3:0] MODE_MUL  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic cout;
        logic zero;
        logic neg;
        logic ovf;
        logic illegal;
    } flags_t;

    function automatic logic is_shift(input logic [3:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_SAR);
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative engine: one-bit-per-cycle shifts (SHL/SHR/SAR) and shift-add multiply.
// Latency: n step cycles for shifts, WIDTH step cycles for MUL; done pulses with the final result.
// No backpressure: the caller holds step high until done and must consume the result that cycle.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CNT_W-1:0] n,
    input  logic             cin,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam logic [CNT_W:0] CNT_MUL = (CNT_W+1)'(WIDTH);
    localparam logic [CNT_W:0] CNT_ONE = (CNT_W+1)'(1);

    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             cout_q, cout_d;
    logic [CNT_W:0]   cnt_q;
    logic [WIDTH:0]   mul_sum;

    // Multiplier keeps the partial product in hi_q and the shrinking multiplier in acc_q.
    assign mul_sum = {1'b0, hi_q} + (acc_q[0] ? {1'b0, a_q} : '0);

    always_comb begin
        acc_d  = acc_q;
        hi_d   = hi_q;
        cout_d = cout_q;
        case (op_q)
            MODE_SHL: begin
                acc_d  = {acc_q[WIDTH-2:0], 1'b0};
                cout_d = acc_q[WIDTH-1];
            end
            MODE_SHR: begin
                acc_d  = {1'b0, acc_q[WIDTH-1:1]};
                cout_d = acc_q[0];
            end
            MODE_SAR: begin
                acc_d  = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                cout_d = acc_q[0];
            end
            MODE_MUL: begin
                hi_d   = mul_sum[WIDTH:1];
                acc_d  = {mul_sum[0], acc_q[WIDTH-1:1]};
                cout_d = |hi_d;
            end
            default: ;
        endcase
    end

    assign done   = step && (cnt_q == CNT_ONE);
    assign result = acc_d;
    assign cout   = cout_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= MODE_AND;
            a_q    <= '0;
            acc_q  <= '0;
            hi_q   <= '0;
            cout_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            op_q   <= op;
            a_q    <= a;
            acc_q  <= (op == MODE_MUL) ? b : a;
            hi_q   <= '0;
            cout_q <= cin;
            cnt_q  <= (op == MODE_MUL) ? CNT_MUL : {1'b0, n};
        end else if (step) begin
            acc_q  <= acc_d;
            hi_q   <= hi_d;
            cout_q <= cout_d;
            cnt_q  <= cnt_q - CNT_ONE;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; one operation in flight.
// Latency: 1 cycle for single-cycle ops, 1+n for shifts by n, 1+WIDTH for MUL.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       mode,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             ovf_flag,
    output logic             illegal
);

    alu_state_t       state_q, state_d;
    flags_t           flags_q;
    logic [WIDTH-1:0] out_q;

    logic             accept;
    logic             iter_op;
    logic [CNT_W-1:0] shift_n;
    logic             iter_done;
    logic [WIDTH-1:0] iter_res;
    logic             iter_cout;

    logic [WIDTH-1:0] b_eff;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             res_cout;
    logic             res_ovf;
    logic             res_ill;

    assign shift_n = in_B[CNT_W-1:0];
    assign accept  = in_valid && (state_q == ST_IDLE) && !enable;
    // A shift by zero has nothing to iterate and completes like a single-cycle op.
    assign iter_op = (mode == MODE_MUL) || (is_shift(mode) && (shift_n != '0));

    always_comb begin
        b_eff    = ((mode == MODE_SUB) || (mode == MODE_SBB)) ? ~in_B : in_B;
        add_cin  = (mode == MODE_ADD) ? 1'b0 : (mode == MODE_SUB) ? 1'b1 : carry_in;
        sum      = {1'b0, in_A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_cin};
        res      = '0;
        res_cout = carry_in;
        res_ovf  = 1'b0;
        res_ill  = 1'b0;
        case (mode)
            MODE_AND: res = in_A & in_B;
            MODE_OR:  res = in_A | in_B;
            MODE_XOR: res = in_A ^ in_B;
            MODE_NOT: res = ~in_A;
            MODE_SHCL: begin
                res      = {in_A[WIDTH-2:0], carry_in};
                res_cout = in_A[WIDTH-1];
            end
            MODE_SHCR: begin
                res      = {carry_in, in_A[WIDTH-1:1]};
                res_cout = in_A[0];
            end
            MODE_ADD, MODE_SUB, MODE_ADC, MODE_SBB: begin
                res      = sum[WIDTH-1:0];
                res_cout = sum[WIDTH];
                res_ovf  = (in_A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in_A[WIDTH-1]);
            end
            MODE_SHL, MODE_SHR, MODE_SAR: res = in_A;
            MODE_MUL: res = '0;
            default: begin
                res_cout = 1'b0;
                res_ill  = 1'b1;
            end
        endcase
    end

    alu_seq_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && iter_op),
        .step   (state_q == ST_BUSY),
        .op     (mode),
        .a      (in_A),
        .b      (in_B),
        .n      (shift_n),
        .cin    (carry_in),
        .done   (iter_done),
        .result (iter_res),
        .cout   (iter_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = iter_op ? ST_BUSY : ST_DONE;
            ST_BUSY: if (iter_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            flags_q <= '0;
        end else if (accept && !iter_op) begin
            out_q           <= res;
            flags_q.cout    <= res_cout;
            flags_q.zero    <= (res == '0);
            flags_q.neg     <= res[WIDTH-1];
            flags_q.ovf     <= res_ovf;
            flags_q.illegal <= res_ill;
        end else if (iter_done) begin
            out_q           <= iter_res;
            flags_q.cout    <= iter_cout;
            flags_q.zero    <= (iter_res == '0);
            flags_q.neg     <= iter_res[WIDTH-1];
            flags_q.ovf     <= 1'b0;
            flags_q.illegal <= 1'b0;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;
    assign carry_out = flags_q.cout;
    assign zero_flag = flags_q.zero;
    assign neg_flag  = flags_q.neg;
    assign ovf_flag  = flags_q.ovf;
    assign illegal   = flags_q.illegal;

endmodule
